bcd_display_conv: RTL

Sequential binary-to-BCD converter between the memory-stage read-data tap of the pipelined core and the 7-segment multiplexer. It captures a 32-bit word on a start pulse and runs an iterative shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents four registered BCD digits (ones/tens/hundreds/thousands) plus an overflow flag to the segment controller. It replaces the combinational digit split, so the display path meets timing at the display clock.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/bcd_add3.sv | 12 +
 rtl/bcd_display_conv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the binary-to-BCD display path: converter state
// encoding, BCD digit width and the BCD register depth derived from word width.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int DIGIT_W = 4;

   // ceil(w * log10(2)) using a fixed-point approximation of log10(2)
   function automatic int bcd_nibbles(input int w);
      return (w * 30103 + 99999) / 100000;
   endfunction

   localparam int BCD_NIBBLES = bcd_nibbles(32);

endpackage

// File: rtl/bcd_add3.sv
// One-nibble double-dabble corrector: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
   import disp_pkg::*;
(
   input  logic [DIGIT_W-1:0] nib_in,
   output logic [DIGIT_W-1:0] nib_out
);

   assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bcd_display_conv.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding
// the 7-segment multiplexer. Optional macro BCD_CONV_SIGNED_EN: two's-complement input.
module bcd_display_conv
   import disp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DIGITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bin_in,
   output logic              busy,
   output logic              done,
   output logic [3:0]        ones,
   output logic [3:0]        tens,
   output logic [3:0]        hundreds,
   output logic [3:0]        thousands,
   output logic              overflow,
   output logic              neg
);

   localparam int NIB   = bcd_nibbles(DATA_W);
   localparam int BCD_W = NIB * DIGIT_W;
   localparam int OUT_W = DIGITS * DIGIT_W;
   localparam int CNT_W = $clog2(DATA_W);

   conv_state_t state, state_nxt;

   logic [DATA_W-1:0]     shift_reg;
   logic [BCD_W-1:0]      bcd_reg;
   logic [BCD_W-1:0]      bcd_adj;
   logic [CNT_W-1:0]      bit_cnt;
   logic [BCD_W+DATA_W-1:0] shift_cat;
   logic [OUT_W-1:0]      digits_r;
   logic                  overflow_r;
   logic                  done_r;
   logic                  load, step, finish;

   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
`ifdef BCD_CONV_SIGNED_EN
      logic signed [DATA_W-1:0] sx;
      sx = x;
      // The most negative value wraps to 2^(DATA_W-1), which is its true magnitude
      return (sx < 0) ? DATA_W'(-sx) : x;
`else
      return x;
`endif
   endfunction

   function automatic logic upper_nonzero(input logic [BCD_W-1:0] b);
      return |b[BCD_W-1:OUT_W];
   endfunction

   function automatic logic [OUT_W-1:0] saturate(input logic [BCD_W-1:0] b,
                                                 input logic ovf);
      return ovf ? {DIGITS{4'd9}} : b[OUT_W-1:0];
   endfunction

   genvar g;
   generate
      for (g = 0; g < NIB; g++) begin : g_add3
         bcd_add3 u_add3 (
            .nib_in  (bcd_reg[g*DIGIT_W +: DIGIT_W]),
            .nib_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
         );
      end
   endgenerate

   assign shift_cat = {bcd_adj, shift_reg} << 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (bit_cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Conversion datapath: capture, then one shift per SHIFT cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg <= '0;
         bcd_reg   <= '0;
         bit_cnt   <= '0;
      end else if (load) begin
         shift_reg <= magnitude(bin_in);
         bcd_reg   <= '0;
         bit_cnt   <= CNT_W'(DATA_W - 1);
      end else if (step) begin
         {bcd_reg, shift_reg} <= shift_cat;
         bit_cnt              <= bit_cnt - CNT_W'(1);
      end
   end

   // Result registers: change only in the done cycle or on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digits_r   <= '0;
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= finish;
         if (finish) begin
            overflow_r <= upper_nonzero(bcd_reg);
            digits_r   <= saturate(bcd_reg, upper_nonzero(bcd_reg));
         end
      end
   end

`ifdef BCD_CONV_SIGNED_EN
   logic neg_cap;
   logic neg_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_cap <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         if (load)   neg_cap <= bin_in[DATA_W-1];
         if (finish) neg_r   <= neg_cap;
      end
   end

   assign neg = neg_r;
`else
   assign neg = 1'b0;
`endif

   assign done      = done_r;
   assign overflow  = overflow_r;
   assign ones      = digits_r[0*DIGIT_W +: DIGIT_W];
   assign tens      = digits_r[1*DIGIT_W +: DIGIT_W];
   assign hundreds  = digits_r[2*DIGIT_W +: DIGIT_W];
   assign thousands = digits_r[3*DIGIT_W +: DIGIT_W];

endmodule
